execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
Y86-64 SEQ execute stage. It sits between decode/register-file and memory/write-back.
- Consumes the instruction fields, the decoded operands value_A/value_B and the fetched constant Value_C.
- Produces Value_E and condition_satisfy_check, which write-back uses to commit cmov/OPq/stack results.
- Owns the condition-code register (ZF, SF, OF) and the halt/status state. Results are registered and qualified by a valid/done handshake.

Parameters:
WIDTH, 64, datapath width in bits.
STACK_STEP, 8, byte adjustment applied to %rsp by call/ret/push/pop.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
exec_valid  input  1  operands and fields are valid this cycle
Ins_Code  input  4  icode
Ins_fun  input  4  ifun
value_A  input  WIDTH  signed operand A from decode
value_B  input  WIDTH  signed operand B from decode
Value_C  input  WIDTH  signed constant from fetch
mem_invalid_check  input  1  fetch address error
instruction_invalid_check  input  1  fetch illegal icode
exec_done  output  1  one-cycle pulse; registered results valid
Value_E  output  WIDTH  signed ALU result
condition_satisfy_check  output  1  Cnd for cmovXX/jXX
ZF, SF, OF  output  1 each  condition-code register
stat  output  3  1 AOK, 2 HLT, 3 ADR, 4 INS

Behaviour:
- Reset state (on reset high at a clk edge):
  - Value_E=0, condition_satisfy_check=0, exec_done=0.
  - ZF=1, SF=0, OF=0; stat=AOK; FSM=RUN.
- FSM has two states:
  - RUN: accepts exec_valid.
  - HALT: ignores exec_valid; outputs and CC hold; exec_done=0. Only reset leaves HALT.
- Latency: exec_valid sampled at edge N gives Value_E/Cnd/CC/stat updated at edge N and exec_done=1 for the following cycle. Back-to-back exec_valid is allowed, one result per cycle.
- ALU result Value_E per icode:
  - 2 cmov: value_A+0
  - 3 irmovq: Value_C
  - 4/5 rmmovq/mrmovq: value_B+Value_C
  - 6 OPq: value_B op value_A; ifun 0 add, 1 sub (B−A), 2 and, 3 xor
  - 8 call, A push: value_B−STACK_STEP
  - 9 ret, B pop: value_B+STACK_STEP
  - 1 nop, 7 jXX: Value_E=0
- All arithmetic is WIDTH-bit two's complement and wraps modulo 2^WIDTH.
- CC update happens only on a valid OPq with ifun≤3:
  - ZF = (result==0); SF = result[MSB].
  - OF for add: operands share a sign and the result sign differs.
  - OF for sub: B and A signs differ and the result sign differs from B.
  - OF for and/xor: 0.
- Cnd is evaluated from CC before this instruction's update (an OPq never tests its own flags):
  - ifun 0 always
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: ~ZF
  - 5 ge: ~(SF^OF)
  - 6 g: ~(SF^OF)&~ZF
  - Cnd=0 for icodes other than 2/7.
- Status priority: mem_invalid_check → ADR; else instruction_invalid_check, an icode >0xB, or an illegal ifun (cmov/jXX >6, OPq >3, other icodes ≠0) → INS; else icode 0 → HLT; else AOK.
- When stat ≠ AOK:
  - CC is unchanged; Value_E=0, Cnd=0.
  - exec_done still pulses.
  - The FSM enters HALT.
- Reset asserted in the same cycle as exec_valid: reset wins and the instruction is discarded.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT…POPQ)
  - ALU ifun codes (ADD, SUB, AND, XOR)
  - condition ifun codes (ALWAYS, LE, L, E, NE, GE, G)
  - stat codes (AOK, HLT, ADR, INS)
  - STACK_STEP default
- One combinational sub-module, y86_alu, computes result/ZF/SF/OF from the operands and the op. Condition evaluation, stat decode and the FSM stay in execute_stage.

Test Plan:
1. Reset → ZF=1, SF=0, OF=0, Value_E=0, stat=1, exec_done=0. Then OPq add with A=5, B=−5 → next cycle exec_done=1, Value_E=0, ZF=1, SF=0, OF=0.
2. OPq sub with A=1, B=0x8000000000000000 → Value_E=0x7FFFFFFFFFFFFFFF, ZF=0, SF=0, OF=1. Then cmovl (icode 2, ifun 2, A=7) → Value_E=7, Cnd=1. Then jg (icode 7, ifun 6) → Cnd=0, CC unchanged.
3. pushq with B=0x100 → Value_E=0xF8. popq with B=0xF8 → 0x100. call with B=0x200 → 0x1F8. ret with B=0x1F8 → 0x200. CC unchanged throughout.
4. rmmovq with B=0x40, C=0x18 → Value_E=0x58. irmovq with C=−3 → Value_E=0xFFFFFFFFFFFFFFFD. Back-to-back exec_valid → exec_done held high for two cycles with matching results.
5. OPq ifun 5 → stat=4, Value_E=0, CC unchanged, FSM HALT. A subsequent add with A=1, B=1 → no exec_done, Value_E still 0. Reset → stat=1, and the add is accepted afterwards (Value_E=2).
6. halt (icode 0) → stat=2, then ignored. Next, mem_invalid_check=1 together with instruction_invalid_check=1 after reset → stat=3 (ADR priority). Reset and exec_valid in the same cycle → no exec_done and reset values present.

Source files
------------

// File: rtl/y86_pkg.sv
// Purpose: shared Y86-64 encodings (icodes, ALU/condition ifuns, status codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes (OPq ifun)
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Condition codes (cmovXX / jXX ifun)
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } exec_state_t;

    localparam int STACK_STEP_DEFAULT = 8;

endpackage

// File: rtl/y86_alu.sv
// Purpose: Y86-64 ALU; computes b op a with ZF/SF/OF. Ports: a, b, fun in; result, zf, sf, of out.
// Latency: combinational.
// Backpressure: none.
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fun,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int MSB = WIDTH - 1;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fun)
            ALU_ADD: begin
                result = b + a;
                // Overflow: like-signed operands producing an opposite-signed sum
                of = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = b - a;
                // Overflow: operand signs differ and the difference flips away from b
                of = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: begin
                result = '0;
                of     = 1'b0;
            end
        endcase
        zf = (result == '0);
        sf = result[MSB];
    end

endmodule

// File: rtl/execute_stage.sv
// Purpose: Y86-64 SEQ execute stage; ALU operand select, Cnd, CC register, status and RUN/HALT FSM.
//   Ports: clk/reset, exec_valid + icode/ifun/operands/fetch errors in; exec_done, Value_E, Cnd, ZF/SF/OF, stat out.
// Latency: results registered on the edge that samples exec_valid; exec_done pulses the following cycle.
// Backpressure: none in RUN (one result per cycle); in HALT exec_valid is ignored until reset.
module execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = STACK_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exec_valid,
    input  logic [3:0]       Ins_Code,
    input  logic [3:0]       Ins_fun,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    input  logic [WIDTH-1:0] Value_C,
    input  logic             mem_invalid_check,
    input  logic             instruction_invalid_check,
    output logic             exec_done,
    output logic [WIDTH-1:0] Value_E,
    output logic             condition_satisfy_check,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic [2:0]       stat
);
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [3:0]       alu_fun;
    logic             alu_zf, alu_sf, alu_of;
    logic             ifun_bad, cnd_raw, cnd, fire;
    stat_t            stat_nxt, stat_q;
    exec_state_t      state_q, state_nxt;

    // Every icode is routed through the ALU; icodes with no arithmetic add 0+0.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = ALU_ADD;
        case (Ins_Code)
            I_CMOVXX: alu_a = value_A;
            I_IRMOVQ: alu_a = Value_C;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = Value_C;
                alu_b = value_B;
            end
            I_OPQ: begin
                alu_a   = value_A;
                alu_b   = value_B;
                alu_fun = Ins_fun;
            end
            I_CALL, I_PUSHQ: begin
                alu_a   = WIDTH'(STACK_STEP);
                alu_b   = value_B;
                alu_fun = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = WIDTH'(STACK_STEP);
                alu_b = value_B;
            end
            default: ;
        endcase
    end

    y86_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fun    (alu_fun),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Condition uses the CC register as it stands before this instruction.
    always_comb begin
        cnd_raw = 1'b0;
        case (Ins_fun)
            C_ALWAYS: cnd_raw = 1'b1;
            C_LE:     cnd_raw = (SF ^ OF) | ZF;
            C_L:      cnd_raw = SF ^ OF;
            C_E:      cnd_raw = ZF;
            C_NE:     cnd_raw = ~ZF;
            C_GE:     cnd_raw = ~(SF ^ OF);
            C_G:      cnd_raw = ~(SF ^ OF) & ~ZF;
            default:  cnd_raw = 1'b0;
        endcase
        cnd = ((Ins_Code == I_CMOVXX) || (Ins_Code == I_JXX)) ? cnd_raw : 1'b0;
    end

    always_comb begin
        case (Ins_Code)
            I_CMOVXX, I_JXX: ifun_bad = (Ins_fun > 4'd6);
            I_OPQ:           ifun_bad = (Ins_fun > 4'd3);
            default:         ifun_bad = (Ins_fun != 4'd0);
        endcase
        if (mem_invalid_check)
            stat_nxt = STAT_ADR;
        else if (instruction_invalid_check || (Ins_Code > I_POPQ) || ifun_bad)
            stat_nxt = STAT_INS;
        else if (Ins_Code == I_HALT)
            stat_nxt = STAT_HLT;
        else
            stat_nxt = STAT_AOK;
    end

    assign fire = (state_q == ST_RUN) && exec_valid;

    always_comb begin
        state_nxt = state_q;
        if (fire && (stat_nxt != STAT_AOK))
            state_nxt = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Value_E                 <= '0;
            condition_satisfy_check <= 1'b0;
            exec_done               <= 1'b0;
            ZF                      <= 1'b1;
            SF                      <= 1'b0;
            OF                      <= 1'b0;
            stat_q                  <= STAT_AOK;
        end else begin
            exec_done <= fire;
            if (fire) begin
                stat_q <= stat_nxt;
                if (stat_nxt == STAT_AOK) begin
                    Value_E                 <= alu_res;
                    condition_satisfy_check <= cnd;
                    if (Ins_Code == I_OPQ) begin
                        ZF <= alu_zf;
                        SF <= alu_sf;
                        OF <= alu_of;
                    end
                end else begin
                    // Faulting instruction: zero the result, leave CC untouched.
                    Value_E                 <= '0;
                    condition_satisfy_check <= 1'b0;
                end
            end
        end
    end

    assign stat = stat_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        exec_valid;
    logic [3:0]  Ins_Code, Ins_fun;
    logic [63:0] value_A, value_B, Value_C;
    logic        mem_invalid_check, instruction_invalid_check;
    logic        exec_done;
    logic [63:0] Value_E;
    logic        condition_satisfy_check;
    logic        ZF, SF, OF;
    logic [2:0]  stat;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_ve;
    logic        m_cnd, m_zf, m_sf, m_of, m_done, m_halt;
    logic [2:0]  m_stat;

    execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .exec_valid                (exec_valid),
        .Ins_Code                  (Ins_Code),
        .Ins_fun                   (Ins_fun),
        .value_A                   (value_A),
        .value_B                   (value_B),
        .Value_C                   (Value_C),
        .mem_invalid_check         (mem_invalid_check),
        .instruction_invalid_check (instruction_invalid_check),
        .exec_done                 (exec_done),
        .Value_E                   (Value_E),
        .condition_satisfy_check   (condition_satisfy_check),
        .ZF                        (ZF),
        .SF                        (SF),
        .OF                        (OF),
        .stat                      (stat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"}, 64'(exec_done), 64'(m_done));
        chk({tag, ".ve"},   Value_E,        m_ve);
        chk({tag, ".cnd"},  64'(condition_satisfy_check), 64'(m_cnd));
        chk({tag, ".zf"},   64'(ZF), 64'(m_zf));
        chk({tag, ".sf"},   64'(SF), 64'(m_sf));
        chk({tag, ".of"},   64'(OF), 64'(m_of));
        chk({tag, ".stat"}, 64'(stat), 64'(m_stat));
    endtask

    task automatic model_reset();
        m_ve = 64'd0; m_cnd = 1'b0; m_done = 1'b0;
        m_zf = 1'b1;  m_sf = 1'b0;  m_of = 1'b0;
        m_stat = 3'd1; m_halt = 1'b0;
    endtask

    // Architectural behaviour of one accepted instruction, straight from the ISA rules.
    task automatic model_step(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                              input logic me, input logic ie);
        logic               bad, lt;
        logic [2:0]         st;
        logic signed [64:0] w;
        logic [63:0]        r;
        if (m_halt) begin
            m_done = 1'b0;
            return;
        end
        m_done = 1'b1;
        if (ic == 4'd2 || ic == 4'd7) bad = (fn > 6);
        else if (ic == 4'd6)          bad = (fn > 3);
        else                          bad = (fn != 0);
        if (me)                          st = 3'd3;
        else if (ie || ic > 4'd11 || bad) st = 3'd4;
        else if (ic == 4'd0)             st = 3'd2;
        else                             st = 3'd1;
        m_stat = st;
        if (st != 3'd1) begin
            m_ve = 64'd0; m_cnd = 1'b0; m_halt = 1'b1;
            return;
        end
        lt = (m_sf != m_of);
        m_cnd = 1'b0;
        if (ic == 4'd2 || ic == 4'd7) begin
            case (fn)
                4'd0: m_cnd = 1'b1;
                4'd1: m_cnd = lt || m_zf;
                4'd2: m_cnd = lt;
                4'd3: m_cnd = m_zf;
                4'd4: m_cnd = !m_zf;
                4'd5: m_cnd = !lt;
                4'd6: m_cnd = !lt && !m_zf;
                default: m_cnd = 1'b0;
            endcase
        end
        case (ic)
            4'd2:       m_ve = a;
            4'd3:       m_ve = c;
            4'd4, 4'd5: m_ve = b + c;
            4'd8, 4'd10: m_ve = b - 64'd8;
            4'd9, 4'd11: m_ve = b + 64'd8;
            4'd6: begin
                m_of = 1'b0;
                case (fn)
                    4'd0: begin
                        w = $signed({b[63], b}) + $signed({a[63], a});
                        r = w[63:0];
                        m_of = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
                    end
                    4'd1: begin
                        w = $signed({b[63], b}) - $signed({a[63], a});
                        r = w[63:0];
                        m_of = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
                    end
                    4'd2:    r = b & a;
                    default: r = b ^ a;
                endcase
                m_ve = r;
                m_zf = (r == 64'd0);
                m_sf = r[63];
            end
            default: m_ve = 64'd0;
        endcase
    endtask

    task automatic issue(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic me, input logic ie);
        exec_valid = 1'b1;
        Ins_Code = ic; Ins_fun = fn;
        value_A = a; value_B = b; Value_C = c;
        mem_invalid_check = me; instruction_invalid_check = ie;
        model_step(ic, fn, a, b, c, me, ie);
        @(posedge clk);
        #1;
        exec_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        exec_valid = 1'b0;
        m_done = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic with_valid);
        reset = 1'b1;
        exec_valid = with_valid;
        Ins_Code = 4'd6; Ins_fun = 4'd0;
        value_A = 64'd1; value_B = 64'd1; Value_C = 64'd0;
        mem_invalid_check = 1'b0; instruction_invalid_check = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exec_valid = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        reset = 1'b0; exec_valid = 1'b0;
        Ins_Code = 4'd0; Ins_fun = 4'd0;
        value_A = 64'd0; value_B = 64'd0; Value_C = 64'd0;
        mem_invalid_check = 1'b0; instruction_invalid_check = 1'b0;
        model_reset();

        // 1: reset state, add 5 + (-5)
        do_reset("t1.reset", 1'b0);
        issue("t1.add", 4'd6, 4'd0, 64'd5, -64'sd5, 64'd0, 1'b0, 1'b0);
        chk("t1.ve_lit", Value_E, 64'd0);
        chk("t1.zf_lit", 64'(ZF), 64'd1);

        // 2: signed-overflow subtract, then cmovl and jg reading those flags
        issue("t2.sub", 4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
        chk("t2.ve_lit", Value_E, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t2.of_lit", 64'(OF), 64'd1);
        issue("t2.cmovl", 4'd2, 4'd2, 64'd7, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("t2.cnd_lit", 64'(condition_satisfy_check), 64'd1);
        issue("t2.jg", 4'd7, 4'd6, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("t2.jg_lit", 64'(condition_satisfy_check), 64'd0);

        // 3: stack pointer adjustments
        issue("t3.push", 4'hA, 4'd0, 64'd0, 64'h100, 64'd0, 1'b0, 1'b0);
        chk("t3.push_lit", Value_E, 64'hF8);
        issue("t3.pop",  4'hB, 4'd0, 64'd0, 64'hF8, 64'd0, 1'b0, 1'b0);
        issue("t3.call", 4'h8, 4'd0, 64'd0, 64'h200, 64'd0, 1'b0, 1'b0);
        chk("t3.call_lit", Value_E, 64'h1F8);
        issue("t3.ret",  4'h9, 4'd0, 64'd0, 64'h1F8, 64'd0, 1'b0, 1'b0);
        idle("t3.idle");

        // 4: address arithmetic and irmovq back-to-back (done stays high)
        issue("t4.rmmov", 4'd4, 4'd0, 64'd0, 64'h40, 64'h18, 1'b0, 1'b0);
        chk("t4.rm_lit", Value_E, 64'h58);
        issue("t4.irmov", 4'd3, 4'd0, 64'd0, 64'd0, -64'sd3, 1'b0, 1'b0);
        chk("t4.ir_lit", Value_E, 64'hFFFF_FFFF_FFFF_FFFD);
        idle("t4.idle");

        // 5: illegal OPq ifun halts; later instruction ignored until reset
        issue("t5.bad", 4'd6, 4'd5, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0);
        chk("t5.stat_lit", 64'(stat), 64'd4);
        issue("t5.ign", 4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0);
        do_reset("t5.reset", 1'b0);
        issue("t5.add", 4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0);
        chk("t5.add_lit", Value_E, 64'd2);

        // 6: halt, ADR priority, reset colliding with exec_valid
        issue("t6.halt", 4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("t6.hlt_lit", 64'(stat), 64'd2);
        issue("t6.ign", 4'd3, 4'd0, 64'd0, 64'd0, 64'd9, 1'b0, 1'b0);
        do_reset("t6.reset", 1'b0);
        issue("t6.adr", 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
        chk("t6.adr_lit", 64'(stat), 64'd3);
        do_reset("t6.rst_vld", 1'b1);
        idle("t6.after");

        // Randomized instruction stream against the model
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [3:0] ic, fn;
            logic me, ie;
            k = $urandom_range(0, 99);
            me = 1'b0; ie = 1'b0;
            if (k < 4) begin
                ic = 4'($urandom_range(0, 15));
                fn = 4'($urandom_range(0, 15));
                me = (k == 0);
                ie = (k == 1);
            end else begin
                ic = 4'($urandom_range(1, 11));
                if (ic == 4'd2 || ic == 4'd7) fn = 4'($urandom_range(0, 6));
                else if (ic == 4'd6)          fn = 4'($urandom_range(0, 3));
                else                          fn = 4'd0;
            end
            issue("rnd", ic, fn, pick_operand(), pick_operand(), pick_operand(), me, ie);
            if (m_halt) begin
                issue("rnd.ign", 4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0);
                do_reset("rnd.reset", 1'b0);
            end else if (k > 90) begin
                idle("rnd.idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
